// File: rtl/csr_regfile_if.sv
// csr_regfile_if: execute-stage read port, commit-stage write/trap/mret inputs and redirect outputs of the CSR file
interface csr_regfile_if;
    logic [11:0] ra;
    logic [63:0] rd;
    logic        ra_illegal;
    logic        wvalid;
    logic [11:0] wa;
    logic [63:0] wd;
    logic        retire;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic        mret;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    modport master (
        output ra, wvalid, wa, wd, retire, trap_valid, trap_pc, trap_cause, trap_tval, mret,
        input  rd, ra_illegal, redirect_valid, redirect_pc
    );
    modport slave (
        input  ra, wvalid, wa, wd, retire, trap_valid, trap_pc, trap_cause, trap_tval, mret,
        output rd, ra_illegal, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage with trap entry, MRET and mcycle/minstret; CSR_MINSTRET_EN adds the minstret counter
module csr_regfile #(
    parameter logic [63:0] RESET_MTVEC = 64'h0
) (
    input logic          clk,
    input logic          reset,
    csr_regfile_if.slave bus
);
    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [63:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] mstatus;
`ifdef CSR_MINSTRET_EN
    logic [63:0] minstret_q, minstret_d;
`endif
    logic        wr;
    // MPP is hardwired to machine mode; only MIE and MPIE are stored
    assign mstatus = {51'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
    // writes only take effect when neither trap nor mret claims the edge
    assign wr = bus.wvalid & ~bus.trap_valid & ~bus.mret;
    assign bus.redirect_valid = bus.trap_valid | bus.mret;
    assign bus.redirect_pc = bus.trap_valid ? mtvec_q : bus.mret ? mepc_q : '0;
    // combinational read of pre-edge state, no write bypass
    always_comb begin
        bus.rd = '0;
        bus.ra_illegal = 1'b0;
        case (bus.ra)
            12'h300: bus.rd = mstatus;
            12'h304: bus.rd = mie_q;
            12'h305: bus.rd = mtvec_q;
            12'h340: bus.rd = mscratch_q;
            12'h341: bus.rd = mepc_q;
            12'h342: bus.rd = mcause_q;
            12'h343: bus.rd = mtval_q;
            12'hB00: bus.rd = mcycle_q;
`ifdef CSR_MINSTRET_EN
            12'hB02: bus.rd = minstret_q;
`else
            12'hB02: bus.rd = '0;
`endif
            12'h344: bus.rd = '0;
            default: bus.ra_illegal = 1'b1;
        endcase
    end
    // next state: trap beats mret beats CSR write; counters run underneath
    always_comb begin
        mst_mie_d = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d = mie_q;
        mtvec_d = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d = mepc_q;
        mcause_d = mcause_q;
        mtval_d = mtval_q;
        mcycle_d = mcycle_q + 64'd1;
`ifdef CSR_MINSTRET_EN
        minstret_d = minstret_q + {63'b0, bus.retire};
`endif
        if (bus.trap_valid) begin
            mepc_d = {bus.trap_pc[63:2], 2'b00};
            mcause_d = bus.trap_cause;
            mtval_d = bus.trap_tval;
            mst_mpie_d = mst_mie_q;
            mst_mie_d = 1'b0;
        end else if (bus.mret) begin
            mst_mie_d = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end
        if (wr) begin
            case (bus.wa)
                12'h300: begin
                    mst_mie_d = bus.wd[3];
                    mst_mpie_d = bus.wd[7];
                end
                12'h304: mie_d = bus.wd;
                12'h305: mtvec_d = {bus.wd[63:2], 2'b00};
                12'h340: mscratch_d = bus.wd;
                12'h341: mepc_d = {bus.wd[63:2], 2'b00};
                12'h342: mcause_d = bus.wd;
                12'h343: mtval_d = bus.wd;
                12'hB00: mcycle_d = bus.wd;
`ifdef CSR_MINSTRET_EN
                12'hB02: minstret_d = bus.wd;
`endif
                default: ;
            endcase
        end
    end
    // state registers; reset overrides every event on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            mst_mie_q <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q <= '0;
            mtvec_q <= {RESET_MTVEC[63:2], 2'b00};
            mscratch_q <= '0;
            mepc_q <= '0;
            mcause_q <= '0;
            mtval_q <= '0;
            mcycle_q <= '0;
`ifdef CSR_MINSTRET_EN
            minstret_q <= '0;
`endif
        end else begin
            mst_mie_q <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q <= mie_d;
            mtvec_q <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q <= mtval_d;
            mcycle_q <= mcycle_d;
`ifdef CSR_MINSTRET_EN
            minstret_q <= minstret_d;
`endif
        end
    end
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed vectors with a CSR-map model checked every cycle plus hand-computed literal checks
module tb_csr_regfile;
    localparam logic [63:0] RM = 64'h0000_0000_8000_0103;
    localparam logic [63:0] MTVEC0 = 64'h0000_0000_8000_0100;
`ifdef CSR_MINSTRET_EN
    localparam bit IE = 1'b1;
`else
    localparam bit IE = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    bit mvalid = 1'b0;
    logic [63:0] csr [logic [11:0]];
    logic [63:0] ms;
    csr_regfile_if bus();
    csr_regfile #(.RESET_MTVEC(RM)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask
    // model: CSR map as an associative array of architecturally visible values
    always @(posedge clk) begin
        if (reset) begin
            csr.delete();
            csr[12'h300] = 64'h1800;
            csr[12'h304] = 0;
            csr[12'h305] = RM & ~64'd3;
            csr[12'h340] = 0;
            csr[12'h341] = 0;
            csr[12'h342] = 0;
            csr[12'h343] = 0;
            csr[12'h344] = 0;
            csr[12'hB00] = 0;
            csr[12'hB02] = 0;
            mvalid = 1'b1;
        end else begin
            ms = csr[12'h300];
            csr[12'hB00] = csr[12'hB00] + 1;
            if (IE && bus.retire) csr[12'hB02] = csr[12'hB02] + 1;
            if (bus.trap_valid) begin
                csr[12'h341] = bus.trap_pc & ~64'd3;
                csr[12'h342] = bus.trap_cause;
                csr[12'h343] = bus.trap_tval;
                csr[12'h300] = 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
            end else if (bus.mret) begin
                csr[12'h300] = 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
            end else if (bus.wvalid && csr.exists(bus.wa)) begin
                if (bus.wa == 12'h300) csr[12'h300] = 64'h1800 | (bus.wd & 64'h88);
                else if (bus.wa == 12'h305 || bus.wa == 12'h341) csr[bus.wa] = bus.wd & ~64'd3;
                else if (bus.wa == 12'hB02) begin
                    if (IE) csr[12'hB02] = bus.wd;
                end else if (bus.wa != 12'h344) csr[bus.wa] = bus.wd;
            end
        end
    end
    // compare DUT outputs against the model once per cycle, mid-cycle
    always @(negedge clk) begin
        if (mvalid && !reset) begin
            chk("m_rd", bus.rd, csr.exists(bus.ra) ? csr[bus.ra] : 64'h0);
            chk("m_ill", {63'b0, bus.ra_illegal}, {63'b0, !csr.exists(bus.ra)});
            chk("m_rv", {63'b0, bus.redirect_valid}, {63'b0, bus.trap_valid | bus.mret});
            if (bus.trap_valid) chk("m_rpc_trap", bus.redirect_pc, csr[12'h305]);
            else if (bus.mret) chk("m_rpc_mret", bus.redirect_pc, csr[12'h341]);
        end
    end
    task automatic rd_chk(input string n, input logic [11:0] a, input logic [63:0] exp, input logic ill);
        bus.ra = a;
        @(negedge clk);
        chk(n, bus.rd, exp);
        chk({n, "_ill"}, {63'b0, bus.ra_illegal}, {63'b0, ill});
        #1;
    endtask
    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        bus.wvalid = 1'b1;
        bus.wa = a;
        bus.wd = d;
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0;
    endtask
    initial begin
        bus.ra = 12'h300; bus.wvalid = 0; bus.wa = 0; bus.wd = 0; bus.retire = 0;
        bus.trap_valid = 0; bus.trap_pc = 0; bus.trap_cause = 0; bus.trap_tval = 0; bus.mret = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rd_chk("mcycle_first", 12'hB00, 64'h0, 1'b0);
        rd_chk("mstatus_rst", 12'h300, 64'h1800, 1'b0);
        chk("rv_rst", {63'b0, bus.redirect_valid}, 64'h0);
        rd_chk("mtvec_rst", 12'h305, MTVEC0, 1'b0);
        rd_chk("unmapped", 12'h7C0, 64'h0, 1'b1);
        wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk("mstatus_mask", 12'h300, 64'h1888, 1'b0);
        wr(12'h305, 64'h1003);
        rd_chk("mtvec_wr", 12'h305, 64'h1000, 1'b0);
        wr(12'h344, 64'hFF);
        rd_chk("mip_ro", 12'h344, 64'h0, 1'b0);
        wr(12'h7C0, 64'h55);
        rd_chk("unmapped_wr", 12'h7C0, 64'h0, 1'b1);
        bus.ra = 12'h300;
        bus.trap_valid = 1; bus.trap_pc = 64'h8000_0006; bus.trap_cause = 2; bus.trap_tval = 64'hdead;
        #1;
        chk("trap_rpc", bus.redirect_pc, 64'h1000);
        chk("trap_rv", {63'b0, bus.redirect_valid}, 64'h1);
        @(posedge clk); #1 bus.trap_valid = 0;
        rd_chk("trap_mepc", 12'h341, 64'h8000_0004, 1'b0);
        rd_chk("trap_mcause", 12'h342, 64'h2, 1'b0);
        rd_chk("trap_mtval", 12'h343, 64'hdead, 1'b0);
        rd_chk("trap_mstatus", 12'h300, 64'h1880, 1'b0);
        bus.mret = 1;
        #1 chk("mret_rpc", bus.redirect_pc, 64'h8000_0004);
        @(posedge clk); #1 bus.mret = 0;
        rd_chk("mret_mstatus", 12'h300, 64'h1888, 1'b0);
        wr(12'h340, 64'h7);
        bus.trap_valid = 1; bus.mret = 1; bus.trap_pc = 64'h100; bus.trap_cause = 3;
        bus.wvalid = 1; bus.wa = 12'h340; bus.wd = 64'h5;
        #1 chk("prio_rpc", bus.redirect_pc, 64'h1000);
        @(posedge clk); #1 bus.trap_valid = 0; bus.mret = 0; bus.wvalid = 0;
        rd_chk("prio_mscratch", 12'h340, 64'h7, 1'b0);
        rd_chk("prio_mepc", 12'h341, 64'h100, 1'b0);
        rd_chk("prio_mstatus", 12'h300, 64'h1880, 1'b0);
        wr(12'h341, 64'h7);
        rd_chk("mepc_mask", 12'h341, 64'h4, 1'b0);
        @(posedge clk); #1;
        bus.ra = 12'hB00; bus.wvalid = 1; bus.wa = 12'hB00; bus.wd = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        chk("mcycle_nobypass", {63'b0, bus.rd == 64'hFFFF_FFFF_FFFF_FFFE}, 64'h0);
        @(posedge clk); #1 bus.wvalid = 0;
        @(negedge clk) chk("mcycle_ld", bus.rd, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk) chk("mcycle_max", bus.rd, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk) chk("mcycle_wrap", bus.rd, 64'h0);
        #1;
        bus.retire = 1;
        repeat (3) @(posedge clk);
        #1 bus.retire = 0;
        rd_chk("minstret_3", 12'hB02, IE ? 64'd3 : 64'd0, 1'b0);
        bus.retire = 1;
        wr(12'hB02, 64'd10);
        bus.retire = 0;
        rd_chk("minstret_wr", 12'hB02, IE ? 64'd10 : 64'd0, 1'b0);
        bus.retire = 1; bus.trap_valid = 1; bus.trap_pc = 64'h200;
        @(posedge clk); #1 bus.retire = 0; bus.trap_valid = 0;
        rd_chk("minstret_trap", 12'hB02, IE ? 64'd11 : 64'd0, 1'b0);
        reset = 1; bus.trap_valid = 1; bus.trap_pc = 64'h44; bus.trap_cause = 9;
        @(posedge clk); #1 reset = 0; bus.trap_valid = 0;
        rd_chk("rst_mepc", 12'h341, 64'h0, 1'b0);
        rd_chk("rst_mcause", 12'h342, 64'h0, 1'b0);
        rd_chk("rst_mstatus", 12'h300, 64'h1800, 1'b0);
        rd_chk("rst_mtvec", 12'h305, MTVEC0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
